md_sched: RTL and testbench
===========================

# md_sched

Multiply/divide scheduler for the five-stage MIPS pipeline. It accepts mult/multu/div/divu/mthi/mtlo issues from the EX stage and models the unit's multi-cycle latency with a busy counter. It owns the HI/LO registers and raises a stall request toward ID while any instruction that touches HI/LO would otherwise collide with an in-flight operation. It sits beside the ALU in EX, and its stall output is ORed into the existing Tuse/Tnew stall logic.

## Interface
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1)
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high reset
- start  in  1  EX-stage instruction is an HI/LO op; qualifies md_op
- md_op  in  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
- A  in  32  rs operand (forwarded)
- B  in  32  rt operand (forwarded)
- id_use_md  in  1  instruction in ID is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- cancel  in  1  abort in-flight op (present only with MD_CANCEL_EN)
- busy  out  1  operation in flight
- stall_md  out  1  stall request to ID/IF
- HI  out  32  HI register
- LO  out  32  LO register

## Operation
- States: IDLE, BUSY. Reset → IDLE, busy=0, HI=0, LO=0, counter=0, pending result=0.
- IDLE, start & md_op∈{1..4}: compute the result from A/B into pending {hi,lo}, load counter with MULT_CYCLES or DIV_CYCLES, go to BUSY.
- mult: {hi,lo} = signed A × signed B (64-bit). multu: unsigned product.
- div: lo = A/B signed, truncated toward zero; hi = remainder with the sign of the dividend. divu: unsigned quotient/remainder.
- Divide by zero: the op still takes DIV_CYCLES with busy asserted; HI/LO are left unchanged at completion.
- IDLE, start & md_op=5: HI←A at the edge. md_op=6: LO←A. Neither sets busy.
- BUSY: the counter decrements each cycle. On the edge where counter==1, HI/LO←pending, counter→0, state→IDLE.
- start while BUSY is ignored, including mthi/mtlo. This cannot happen in legal pipeline flow because of the stall.
- stall_md = id_use_md & (busy | (start & md_op∈{1..4})). This is combinational. mfhi/mflo never read a stale value.
- HI/LO are read directly by EX-stage mfhi/mflo. There is no forwarding inside the block.

## Timing
- Edge E0 samples start with a mult op. busy=1 during cycles 1..MULT_CYCLES. HI/LO are updated on edge E_MULT_CYCLES, and busy=0 in that same following cycle.
- stall_md rises in cycle 0 (combinational on start) when id_use_md=1. It stays high through the last busy cycle.
- mthi/mtlo: HI/LO visible one cycle after the issuing edge. Zero stall.
- Back-to-back: a new start is accepted in the first cycle with busy=0.
- Reset asserted mid-BUSY: next edge → IDLE, HI=LO=0. The pending result is discarded.
- reset and start in the same cycle: reset wins.

## Configuration
- MD_CANCEL_EN defined: adds port cancel. When cancel=1 in BUSY, the next edge → IDLE, busy=0, and HI/LO keep their pre-op values. When cancel=1 in IDLE, the same-cycle start is suppressed. This supports exception flush in the later stage.
- MD_CANCEL_EN undefined: no cancel port. An op always runs to completion.

## Test plan
- mult A=0xFFFFFFFD (−3), B=5 → busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFF1. multu with the same operands → HI=0x00000004, LO=0xFFFFFFF1.
- div A=0xFFFFFFF9 (−7), B=2 → after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu A=7, B=2 → LO=3, HI=1.
- mult issued, id_use_md=1 (mflo in ID) → stall_md high in the issue cycle and all 5 busy cycles. It drops in the same cycle busy drops, and the mflo then reads the new LO.
- mthi A=0x12345678 followed by mtlo A=0x9ABCDEF0 on consecutive cycles → HI/LO updated one cycle after each, busy never asserted.
- divu B=0 with HI=0xAAAA0000, LO=0x0000BBBB → busy 10 cycles, HI/LO unchanged after completion.
- Reset at cycle 3 of a div → IDLE, HI=LO=0, busy=0. With MD_CANCEL_EN, cancel at cycle 3 → busy=0 next cycle, HI/LO keep their prior values.

Source files
------------

// File: rtl/md_sched.sv
// Multiply/divide scheduler: owns HI/LO, models unit latency with a busy counter, stalls ID on HI/LO hazards.
// Optional feature macro: MD_CANCEL_EN (adds the cancel port for exception flush).
module md_sched #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        id_use_md,
`ifdef MD_CANCEL_EN
    input  logic        cancel,
`endif
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int unsigned MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CW   = $clog2(MAXC + 1);

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_e;

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [31:0]   hi_q, lo_q;
    logic [31:0]   pend_hi_q, pend_lo_q;
    logic          pend_ok_q;
    logic          busy_q;

    logic          cancel_w;
    logic          is_md;
    logic [31:0]   res_hi_d, res_lo_d;
    logic          res_ok_d;
    logic [CW-1:0] cyc_d;

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic signed [31:0] quo_s, rem_s;
    logic        [31:0] quo_u, rem_u;
    logic               b_zero;

`ifdef MD_CANCEL_EN
    assign cancel_w = cancel;
`else
    assign cancel_w = 1'b0;
`endif

    assign is_md  = start && (md_op >= 3'd1) && (md_op <= 3'd4);
    assign b_zero = (B == '0);

    assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prod_u = {32'b0, A} * {32'b0, B};
    assign quo_s  = $signed(A) / $signed(B);
    assign rem_s  = $signed(A) % $signed(B);
    assign quo_u  = A / B;
    assign rem_u  = A % B;

    always_comb begin
        res_hi_d = '0;
        res_lo_d = '0;
        res_ok_d = 1'b1;
        cyc_d    = CW'(MULT_CYCLES);
        case (md_op)
            3'd1: {res_hi_d, res_lo_d} = prod_s;
            3'd2: {res_hi_d, res_lo_d} = prod_u;
            3'd3: begin
                res_hi_d = rem_s;
                res_lo_d = quo_s;
                res_ok_d = !b_zero;
                cyc_d    = CW'(DIV_CYCLES);
            end
            3'd4: begin
                res_hi_d = rem_u;
                res_lo_d = quo_u;
                res_ok_d = !b_zero;
                cyc_d    = CW'(DIV_CYCLES);
            end
            default: ;
        endcase
    end

    // Result is computed at issue and parked; HI/LO only change when the latency has elapsed.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_ok_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && !cancel_w) begin
                        if (is_md) begin
                            pend_hi_q <= res_hi_d;
                            pend_lo_q <= res_lo_d;
                            pend_ok_q <= res_ok_d;
                            cnt_q     <= cyc_d;
                            state_q   <= S_BUSY;
                            busy_q    <= 1'b1;
                        end else if (md_op == 3'd5) begin
                            hi_q <= A;
                        end else if (md_op == 3'd6) begin
                            lo_q <= A;
                        end
                    end
                end
                S_BUSY: begin
                    if (cancel_w) begin
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == CW'(1)) begin
                        if (pend_ok_q) begin
                            hi_q <= pend_hi_q;
                            lo_q <= pend_lo_q;
                        end
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign stall_md = id_use_md & (busy_q | is_md);
    assign HI       = hi_q;
    assign LO       = lo_q;

endmodule

// File: tb/tb_md_sched.sv
// Randomized bench for md_sched against a completion-time reference model of HI/LO and latency.
module tb_md_sched;

    localparam int unsigned MC = 5;
    localparam int unsigned DC = 10;

    logic        clk = 1'b0;
    logic        reset, start, id_use_md;
    logic [2:0]  md_op;
    logic [31:0] A, B;
    logic        busy, stall_md;
    logic [31:0] HI, LO;
    logic        cancel_r = 1'b0;

    int total = 0;
    int bad   = 0;

    // Reference model: an accepted op finishes on a known future edge number.
    longint      edge_n   = 0;
    longint      m_done   = 0;
    bit          m_active = 0;
    logic [31:0] m_hi = '0, m_lo = '0, m_phi = '0, m_plo = '0;
    bit          m_ok = 0;

    md_sched #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .md_op     (md_op),
        .A         (A),
        .B         (B),
        .id_use_md (id_use_md),
`ifdef MD_CANCEL_EN
        .cancel    (cancel_r),
`endif
        .busy      (busy),
        .stall_md  (stall_md),
        .HI        (HI),
        .LO        (LO)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input logic rst, input logic st, input logic [2:0] op,
                              input logic [31:0] a, input logic [31:0] b, input logic cx);
        longint la, lb, qa, q, r;
        longint unsigned up;
        edge_n++;
        if (rst) begin
            m_hi = '0; m_lo = '0; m_active = 0;
        end else if (m_active) begin
            if (cx) m_active = 0;
            else if (edge_n == m_done) begin
                if (m_ok) begin m_hi = m_phi; m_lo = m_plo; end
                m_active = 0;
            end
        end else if (st && !cx) begin
            la = longint'($signed(a));
            lb = longint'($signed(b));
            case (op)
                3'd1: begin
                    q = la * lb; {m_phi, m_plo} = q; m_ok = 1;
                    m_active = 1; m_done = edge_n + MC;
                end
                3'd2: begin
                    up = longint'({32'b0, a}) * longint'({32'b0, b});
                    {m_phi, m_plo} = up; m_ok = 1;
                    m_active = 1; m_done = edge_n + MC;
                end
                3'd3: begin
                    m_ok = (b != 0);
                    if (m_ok) begin
                        qa = (la < 0 ? -la : la) / (lb < 0 ? -lb : lb);
                        q  = ((la < 0) != (lb < 0)) ? -qa : qa;
                        r  = la - q * lb;
                        m_plo = 32'(q); m_phi = 32'(r);
                    end
                    m_active = 1; m_done = edge_n + DC;
                end
                3'd4: begin
                    m_ok = (b != 0);
                    if (m_ok) begin m_plo = a / b; m_phi = a % b; end
                    m_active = 1; m_done = edge_n + DC;
                end
                3'd5: m_hi = a;
                3'd6: m_lo = a;
                default: ;
            endcase
        end
    endtask

    task automatic step(input logic rst, input logic st, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b, input logic use_md);
        logic exp_stall;
        @(negedge clk);
        reset = rst; start = st; md_op = op; A = a; B = b; id_use_md = use_md;
        #1;
        exp_stall = use_md && (m_active || (st && op >= 3'd1 && op <= 3'd4));
        check("stall_md", {63'b0, stall_md}, {63'b0, exp_stall});
        @(posedge clk);
        model_edge(rst, st, op, a, b, cancel_r);
        #1;
        check("busy", {63'b0, busy}, {63'b0, m_active});
        check("HI", {32'b0, HI}, {32'b0, m_hi});
        check("LO", {32'b0, LO}, {32'b0, m_lo});
    endtask

    task automatic idle(input int n, input logic use_md);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd0, '0, '0, use_md);
    endtask

    initial begin
        logic [31:0] ra, rb;
        reset = 1'b1; start = 1'b0; md_op = '0; A = '0; B = '0; id_use_md = 1'b0;
        step(1'b1, 1'b0, 3'd0, '0, '0, 1'b0);
        step(1'b1, 1'b1, 3'd1, 32'd3, 32'd4, 1'b0);
        check("reset_busy", {63'b0, busy}, 64'd0);

        step(1'b0, 1'b1, 3'd1, 32'hFFFFFFFD, 32'd5, 1'b1);
        idle(MC, 1'b1);
        check("mult_hi", {32'b0, HI}, 64'h0000_0000_FFFF_FFFF);
        check("mult_lo", {32'b0, LO}, 64'h0000_0000_FFFF_FFF1);

        step(1'b0, 1'b1, 3'd2, 32'hFFFFFFFD, 32'd5, 1'b0);
        step(1'b0, 1'b1, 3'd5, 32'h11111111, '0, 1'b0);
        idle(MC - 1, 1'b0);
        check("multu_hi", {32'b0, HI}, 64'h0000_0000_0000_0004);
        check("multu_lo", {32'b0, LO}, 64'h0000_0000_FFFF_FFF1);

        step(1'b0, 1'b1, 3'd3, 32'hFFFFFFF9, 32'd2, 1'b1);
        idle(DC, 1'b1);
        check("div_lo", {32'b0, LO}, 64'h0000_0000_FFFF_FFFD);
        check("div_hi", {32'b0, HI}, 64'h0000_0000_FFFF_FFFF);

        step(1'b0, 1'b1, 3'd4, 32'd7, 32'd2, 1'b0);
        idle(DC, 1'b0);
        check("divu_lo", {32'b0, LO}, 64'd3);
        check("divu_hi", {32'b0, HI}, 64'd1);

        step(1'b0, 1'b1, 3'd5, 32'h12345678, '0, 1'b1);
        check("mthi", {32'b0, HI}, 64'h0000_0000_1234_5678);
        step(1'b0, 1'b1, 3'd6, 32'h9ABCDEF0, '0, 1'b1);
        check("mtlo", {32'b0, LO}, 64'h0000_0000_9ABC_DEF0);

        step(1'b0, 1'b1, 3'd5, 32'hAAAA0000, '0, 1'b0);
        step(1'b0, 1'b1, 3'd6, 32'h0000BBBB, '0, 1'b0);
        step(1'b0, 1'b1, 3'd4, 32'd99, 32'd0, 1'b0);
        idle(DC, 1'b0);
        check("dz_hi", {32'b0, HI}, 64'h0000_0000_AAAA_0000);
        check("dz_lo", {32'b0, LO}, 64'h0000_0000_0000_BBBB);

`ifdef MD_CANCEL_EN
        step(1'b0, 1'b1, 3'd3, 32'd100, 32'd7, 1'b0);
        idle(2, 1'b0);
        cancel_r = 1'b1;
        step(1'b0, 1'b0, 3'd0, '0, '0, 1'b0);
        cancel_r = 1'b0;
        check("cancel_hi", {32'b0, HI}, 64'h0000_0000_AAAA_0000);
        idle(DC, 1'b0);
        check("cancel_lo", {32'b0, LO}, 64'h0000_0000_0000_BBBB);
`endif

        step(1'b0, 1'b1, 3'd3, 32'd100, 32'd7, 1'b0);
        idle(2, 1'b0);
        step(1'b1, 1'b0, 3'd0, '0, '0, 1'b0);
        check("rst_mid_hi", {32'b0, HI}, 64'd0);
        check("rst_mid_busy", {63'b0, busy}, 64'd0);

        for (int i = 0; i < 600; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) - 32'd10 : $urandom;
            case ($urandom_range(0, 7))
                0:       rb = '0;
                1, 2:    rb = 32'($urandom_range(0, 20)) - 32'd10;
                default: rb = $urandom;
            endcase
            if (ra == 32'h80000000 && rb == 32'hFFFFFFFF) rb = 32'd1;
            step(($urandom_range(0, 149) == 0), ($urandom_range(0, 2) == 0),
                 3'($urandom_range(0, 7)), ra, rb, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
